// File: rtl/jtdsp16_pio_host_if.sv
// Bundle of the DSP16 PIO pins, host requester ports and receive-FIFO readback.
// The slave modport is the device-side controller; the master modport drives it.
interface jtdsp16_pio_host_if #(
    parameter int FIFO_AW = 2
);
    logic [15:0]      pbus_out;
    logic             pods_n;
    logic             pids_n;
    logic             psel;
    logic [15:0]      pbus_in;
    logic             dsp_irq;

    logic             a_req;
    logic             a_sel;
    logic [15:0]      a_din;
    logic             a_ack;
    logic             b_req;
    logic             b_sel;
    logic [15:0]      b_din;
    logic             b_ack;

    logic             rd_valid;
    logic [15:0]      rd_data;
    logic             rd_sel;
    logic             rd_pop;
    logic [FIFO_AW:0] fifo_cnt;
    logic [1:0]       mbox_full;
    logic             ovf;
    logic             udf;
    logic             flag_clr;

    modport slave (
        input  pbus_out, pods_n, pids_n, psel,
        input  a_req, a_sel, a_din, b_req, b_sel, b_din,
        input  rd_pop, flag_clr,
        output pbus_in, dsp_irq, a_ack, b_ack,
        output rd_valid, rd_data, rd_sel, fifo_cnt, mbox_full, ovf, udf
    );

    modport master (
        output pbus_out, pods_n, pids_n, psel,
        output a_req, a_sel, a_din, b_req, b_sel, b_din,
        output rd_pop, flag_clr,
        input  pbus_in, dsp_irq, a_ack, b_ack,
        input  rd_valid, rd_data, rd_sel, fifo_cnt, mbox_full, ovf, udf
    );
endinterface

// File: rtl/jtdsp16_pio_host.sv
// DSP16 parallel-port device controller: show-ahead receive FIFO for DSP writes,
// two single-entry input mailboxes loaded by two arbitrated host requesters.
module jtdsp16_pio_host #(
    parameter int FIFO_AW = 2
) (
    input logic                clk,
    input logic                rst,
    jtdsp16_pio_host_if.slave  bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    typedef enum logic {PRIO_A, PRIO_B} prio_e;

    logic               pods_n_l_q, pids_n_l_q;
    logic [16:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic [15:0]        mbox_q [2];
    logic [1:0]         full_q, full_d;
    logic               irq_q;
    logic               a_ack_q, b_ack_q;
    logic               ovf_q, ovf_d, udf_q, udf_d;
    prio_e              prio_q, prio_d;

    logic wr_ev, rd_ev, fifo_full, pop, push;
    logic a_elig, b_elig, contend, a_gnt, b_gnt, udf_set;

    always_comb begin
        wr_ev     = ~bus.pods_n & pods_n_l_q;
        rd_ev     = ~bus.pids_n & pids_n_l_q;
        fifo_full = (cnt_q == FULL_CNT);
        pop       = bus.rd_pop & (cnt_q != '0);
        // A push into a full FIFO is accepted when the head leaves on the same edge
        push      = wr_ev & (~fifo_full | pop);

        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CNT_ONE;
        else if (pop && !push)
            cnt_d = cnt_q - CNT_ONE;

        ovf_d = bus.flag_clr ? 1'b0 : (ovf_q | (wr_ev & fifo_full & ~pop));
    end

    always_comb begin
        a_elig  = bus.a_req & ~full_q[bus.a_sel];
        b_elig  = bus.b_req & ~full_q[bus.b_sel];
        contend = a_elig & b_elig & (bus.a_sel == bus.b_sel);
        a_gnt   = a_elig & (~contend | (prio_q == PRIO_A));
        b_gnt   = b_elig & (~contend | (prio_q == PRIO_B));

        prio_d = prio_q;
        if (contend)
            prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;

        full_d  = full_q;
        udf_set = 1'b0;
        if (rd_ev) begin
            udf_set            = ~full_q[bus.psel];
            full_d[bus.psel]   = 1'b0;
        end
        if (a_gnt)
            full_d[bus.a_sel] = 1'b1;
        if (b_gnt)
            full_d[bus.b_sel] = 1'b1;

        udf_d = bus.flag_clr ? 1'b0 : (udf_q | udf_set);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pods_n_l_q <= 1'b1;
            pids_n_l_q <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            mbox_q[0]  <= '0;
            mbox_q[1]  <= '0;
            full_q     <= '0;
            irq_q      <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            prio_q     <= PRIO_A;
        end else begin
            pods_n_l_q <= bus.pods_n;
            pids_n_l_q <= bus.pids_n;
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            cnt_q   <= cnt_d;
            if (a_gnt)
                mbox_q[bus.a_sel] <= bus.a_din;
            if (b_gnt)
                mbox_q[bus.b_sel] <= bus.b_din;
            full_q  <= full_d;
            irq_q   <= |full_q;
            a_ack_q <= a_gnt;
            b_ack_q <= b_gnt;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            prio_q  <= prio_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {bus.psel, bus.pbus_out};
    end

    assign bus.rd_valid  = (cnt_q != '0);
    assign bus.rd_sel    = mem_q[rd_ptr_q][16];
    assign bus.rd_data   = mem_q[rd_ptr_q][15:0];
    assign bus.fifo_cnt  = cnt_q;
    assign bus.pbus_in   = mbox_q[bus.psel];
    assign bus.dsp_irq   = irq_q;
    assign bus.a_ack     = a_ack_q;
    assign bus.b_ack     = b_ack_q;
    assign bus.mbox_full = full_q;
    assign bus.ovf       = ovf_q;
    assign bus.udf       = udf_q;
endmodule
